alu_issue: RTL
==============

# alu_issue

Two-stage issue and writeback stage wrapped around the 16-bit combinational ALU. It accepts one instruction per cycle over a valid/ready handshake and reads two operands from an internal 8×16 register file. It registers the operands and opcode into the ALU inputs, then writes the ALU result, or an immediate, back to the destination register one cycle later. Back-to-back dependencies are handled by forwarding, so the stage never stalls for a read-after-write hazard.

## Interface
- NREGS, 8, register-file depth; index width 3 bits; r0 reads as zero and ignores writes
- WIDTH, 16, datapath width; must match the ALU
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage can accept; equals !hold
- instr_ld  in  1  1 = load immediate into rd; ALU result ignored
- instr_op  in  3  ALU opcode: 000 and, 001 or, 010 add, 110 sub, 111 slt; others illegal
- instr_rd, instr_rs, instr_rt  in  3 each  destination, x-source, y-source
- instr_imm  in  16  immediate for instr_ld
- hold  in  1  freezes acceptance only; the EX stage still drains
- alu_x, alu_y  out  16  registered ALU operands (x from rs, y from rt)
- alu_opcode  out  3  registered opcode to ALU
- alu_s  in  16  combinational ALU result for the current alu_x/alu_y/alu_opcode
- res_valid  out  1  one-cycle pulse: a writeback occurred this edge
- res_rd  out  3  destination of the retired instruction
- res_data  out  16  value written
- err  out  1  sticky: illegal opcode seen; cleared only by rst
- retired  out  16  count of retired instructions; wraps 0xFFFF→0x0000

## Operation
- Accept: an instruction is accepted when instr_valid && instr_ready at a rising edge.
- ID/issue (accept cycle):
  - rs and rt are read combinationally from the register file, through the forwarding mux.
  - The EX register captures: valid, ld, op, rd, imm, alu_x, alu_y.
- Forwarding priority for each source index:
  - index 0 → 0.
  - Otherwise, if EX is valid and its rd equals the index (rd≠0), use EX's writeback value: imm when ld, else alu_s.
  - Otherwise, use the register-file content.
- EX (next cycle):
  - The ALU evaluates combinationally.
  - At the edge, wb_value = ld ? imm : alu_s is written into rf[rd] unless rd=0.
  - The same edge registers res_valid=1, res_rd, res_data=wb_value, and increments retired.
- Writes to rd=0:
  - Retire normally: res_valid pulses and retired increments.
  - The register file is not modified, and res_data still shows wb_value.
- Illegal opcode (011, 100, 101) with ld=0:
  - The instruction is accepted and retires with no register write.
  - res_valid pulses with res_data=0, err sets, and retired increments.
- With ld=1, instr_op is don't-care; alu_opcode is registered as 000.
- An empty EX does not change alu_x, alu_y or alu_opcode; they hold their last values.
- hold=1: no acceptance. An instruction already in EX still retires; EX then becomes empty.

## Timing
- Reset (synchronous) values:
  - All rf entries 0; EX empty.
  - alu_x=0, alu_y=0, alu_opcode=000.
  - res_valid=0, res_rd=0, res_data=0, err=0, retired=0.
  - instr_ready=!hold, including during the rst cycle, but nothing is accepted while rst=1.
- Latency: accepted at edge N → operands on alu_x/alu_y after N → written back and res_valid high after edge N+1.
- Throughput: 1 instruction per cycle when instr_valid=1 and hold=0.
- Dependent pair A (edge N), B (edge N+1) with B.rs=A.rd: B sees A's result via forwarding in cycle N+1.
- Pair separated by one cycle (B at N+2): A is already in the rf after edge N+1, so B reads the rf directly.
- Simultaneous retire and accept: the retire writes rf; the new instruction's operands come from forwarding, so they are never stale.
- rst mid-operation: an in-flight EX instruction is discarded with no write and no res_valid; err and retired clear.
- Combinational path: alu_x/alu_y regs → ALU → forward mux → alu_x/alu_y regs. This path is within one cycle by design.

## Test plan
- Reset, then ld r1=0x0005, ld r2=0x0003, add r3=r1+r2 → res pulses (1,0x0005),(2,0x0003),(3,0x0008) on three consecutive cycles; retired=3.
- Back-to-back forwarding chain: ld r1=0x00F0; or r2=r1|r1; and r3=r2&r1, issued on consecutive cycles → res_data 0x00F0, 0x00F0, 0x00F0; alu_x on the third instruction is 0x00F0.
- sub r4=r1−r2 with r1=0x0003, r2=0x0005 → 0xFFFE; slt r5=(r1<r2) → 0x0001.
- Write to r0: ld r0=0x1234, then add r6=r0+r0 → first res_data=0x1234, second 0x0000; rf[0] stays 0.
- Illegal op 100 → res_valid=1, res_data=0, no rf change, err=1 and stays 1; following legal instructions retire normally.
- hold and reset: assert hold with an instruction in EX → that instruction retires and instr_ready=0; release hold. Assert rst while an instruction is in EX → no res_valid, retired=0, all regs read 0. Issue 0x10000 instructions → retired wraps to 0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback stage around an external 16-bit
// combinational ALU. Accepts one instruction per cycle, reads two operands
// from an internal register file (r0 hard-wired to zero), registers them
// into the ALU inputs, and writes the ALU result (or an immediate) back to
// the destination register on the following edge. A single-entry EX stage
// forwards its writeback value to the instruction being issued, so
// read-after-write hazards never stall.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   instr_valid/ready   issue handshake; instr_ready = !hold
//   instr_ld            load instr_imm into rd (ALU result ignored)
//   instr_op            ALU opcode (000 and, 001 or, 010 add, 110 sub, 111 slt)
//   instr_rd/rs/rt      destination / x-source / y-source indices
//   instr_imm           immediate for loads
//   hold                blocks acceptance; EX still drains
//   alu_x/alu_y         registered ALU operands
//   alu_opcode          registered ALU opcode
//   alu_s               combinational ALU result
//   res_valid/rd/data   one-cycle writeback report
//   err                 sticky illegal-opcode flag
//   retired             wrapping retired-instruction counter
module alu_issue #(
  parameter int NREGS = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             instr_ld,
  input  logic [2:0]       instr_op,
  input  logic [2:0]       instr_rd,
  input  logic [2:0]       instr_rs,
  input  logic [2:0]       instr_rt,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic             hold,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_s,
  output logic             res_valid,
  output logic [2:0]       res_rd,
  output logic [WIDTH-1:0] res_data,
  output logic             err,
  output logic [15:0]      retired
);

  logic [WIDTH-1:0] rf [NREGS];

  logic             ex_valid;
  logic             ex_ld;
  logic             ex_ill;
  logic [2:0]       ex_rd;
  logic [WIDTH-1:0] ex_imm;

  logic             accept;
  logic             in_ill;
  logic [WIDTH-1:0] wb_value;
  logic             ex_fwd;
  logic [WIDTH-1:0] src_x;
  logic [WIDTH-1:0] src_y;

  assign instr_ready = !hold;
  assign accept      = instr_valid && instr_ready && !rst;
  assign in_ill      = !instr_ld && (instr_op inside {3'b011, 3'b100, 3'b101});
  assign wb_value    = ex_ld ? ex_imm : alu_s;

  // An illegal instruction in EX never writes the register file, so it must
  // not forward either; its rd is read from the register file instead.
  assign ex_fwd = ex_valid && !ex_ill && (ex_rd != '0);

  always_comb begin
    src_x = '0;
    src_y = '0;
    if (instr_rs != '0) begin
      if (ex_fwd && (ex_rd == instr_rs)) src_x = wb_value;
      else                               src_x = rf[instr_rs];
    end
    if (instr_rt != '0) begin
      if (ex_fwd && (ex_rd == instr_rt)) src_y = wb_value;
      else                               src_y = rf[instr_rt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
      ex_valid   <= 1'b0;
      ex_ld      <= 1'b0;
      ex_ill     <= 1'b0;
      ex_rd      <= '0;
      ex_imm     <= '0;
      alu_x      <= '0;
      alu_y      <= '0;
      alu_opcode <= '0;
      res_valid  <= 1'b0;
      res_rd     <= '0;
      res_data   <= '0;
      err        <= 1'b0;
      retired    <= '0;
    end else begin
      // Writeback of the instruction currently in EX.
      res_valid <= ex_valid;
      if (ex_valid) begin
        res_rd  <= ex_rd;
        retired <= retired + 16'd1;
        if (ex_ill) begin
          res_data <= '0;
          err      <= 1'b1;
        end else begin
          res_data <= wb_value;
          if (ex_rd != '0) rf[ex_rd] <= wb_value;
        end
      end

      // Issue into EX; ALU operand registers hold when nothing is accepted.
      ex_valid <= accept;
      if (accept) begin
        ex_ld      <= instr_ld;
        ex_ill     <= in_ill;
        ex_rd      <= instr_rd;
        ex_imm     <= instr_imm;
        alu_x      <= src_x;
        alu_y      <= src_y;
        alu_opcode <= instr_ld ? 3'b000 : instr_op;
      end
    end
  end

endmodule
